mips_cpu_sequencer: RTL and testbench
=====================================

MIPS_CPU_SEQUENCER -- requirements
Module: mips_cpu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: opcode  in  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have: funct  in  6  instruction[5:0] from the instruction register.
REQ-005 SHALL have: pc_is_zero  in  1  program counter equals 0x00000000 (halt address).
REQ-006 SHALL have: mem_waitrequest  in  1  memory stall, Avalon-style.
REQ-007 SHALL have: state  out  3  current state encoding.
REQ-008 SHALL have: mem_read, mem_write  out  1 each  memory strobes.
REQ-009 SHALL have: ir_enable  out  1  instruction register load strobe.
REQ-010 SHALL have: pc_enable  out  1  PC update strobe.
REQ-011 SHALL have: reg_write_enable  out  1  register-file write strobe.
REQ-012 SHALL have: active  out  1  CPU running, 0 once halted.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT next cycle.
REQ-014 FETCH: if pc_is_zero=1, SHALL go to HALT without asserting mem_read; otherwise SHALL assert mem_read.
REQ-015 FETCH with mem_waitrequest=1: SHALL hold state, keep mem_read high, keep ir_enable low.
REQ-016 FETCH with mem_waitrequest=0: SHALL assert ir_enable that cycle and go to DECODE.
REQ-017 DECODE: SHALL always go to EXEC after one cycle; no strobes asserted.
REQ-018 EXEC: SHALL assert pc_enable for exactly one cycle.
REQ-018a EXEC, load or store: next state SHALL be MEM.
REQ-018b EXEC, writing instruction: next state SHALL be WB.
REQ-018c EXEC, any other instruction: next state SHALL be FETCH.
REQ-019 Loads SHALL be opcodes 0x20-0x26; stores SHALL be 0x28, 0x29, 0x2B.
REQ-020 Writing instructions SHALL be all loads, JAL (0x03), opcodes 0x08-0x0F, and opcode 0x00 except funct 0x08 (JR), 0x11, 0x13, 0x18-0x1B.
REQ-021 MEM: SHALL assert mem_read for loads or mem_write for stores, never both.
REQ-022 MEM: SHALL hold while mem_waitrequest=1.
REQ-022a MEM, waitrequest=0, load: next state SHALL be WB.
REQ-022b MEM, waitrequest=0, store: next state SHALL be FETCH.
REQ-023 WB: SHALL assert reg_write_enable for one cycle, then go to FETCH.
REQ-024 HALT: SHALL be terminal until reset; all strobes 0; active=0.
REQ-025 All strobe outputs SHALL be combinational decodes of registered state and inputs; no strobe SHALL assert outside its listed state.
REQ-026 Undefined opcodes SHALL take the EXEC->FETCH path (no MEM, no WB).

Reset
REQ-027 While rst_n=0: state=FETCH, active=1; mem_read, mem_write, ir_enable, pc_enable, reg_write_enable SHALL all be 0, gated by rst_n.
REQ-028 Reset assertion mid-transaction, including during a stalled MEM, SHALL abort immediately with no further strobes.
REQ-029 After rst_n deasserts, the first rising edge SHALL evaluate FETCH.

Structure
REQ-030 State enum, opcode constants and funct constants SHALL live in package mips_cpu_pkg.
REQ-031 Opcode classification (is_load, is_store, writes_reg) SHALL be a combinational sub-module mips_cpu_opcode_class.

Verification
REQ-032 ADDU (op 0x00, funct 0x21), no stall -> states 0,1,2,4,0; ir_enable on cycle 1; pc_enable in EXEC; reg_write_enable in WB.
REQ-033 LW (0x23), waitrequest high 3 cycles in FETCH and 2 in MEM -> FETCH held 4 cycles, MEM held 3 cycles; ir_enable exactly once; WB then FETCH.
REQ-034 SW (0x2B) -> 0,1,2,3,0; mem_write only in MEM; reg_write_enable never asserted.
REQ-035 JR (op 0x00, funct 0x08) followed by pc_is_zero=1 in FETCH -> HALT, active=0, mem_read never asserted; state stays 5 for 10 cycles.
REQ-036 rst_n pulled low while MEM stalled on LW -> state=0 and all strobes 0 asynchronously; normal fetch after release.
REQ-037 Undefined opcode 0x3F -> 0,1,2,0 with only pc_enable pulsed.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and instruction-field constants for the multi-cycle MIPS control sequencer.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLwr     = 6'h26;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FunctJr    = 6'h08;
  localparam logic [5:0] FunctMthi  = 6'h11;
  localparam logic [5:0] FunctMtlo  = 6'h13;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctDivu  = 6'h1B;

endpackage

// File: rtl/mips_cpu_opcode_class.sv
// Combinational classification of the instruction register into load / store / register-writing.
import mips_cpu_pkg::*;

module mips_cpu_opcode_class (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_load,
  output logic       is_store,
  output logic       writes_reg
);

  logic special_writes;

  always_comb begin
    is_load  = (opcode >= OpLb) && (opcode <= OpLwr);
    is_store = (opcode == OpSb) || (opcode == OpSh) || (opcode == OpSw);
    // JR, MTHI/MTLO and the multiply/divide group leave the GPR file untouched
    special_writes = !((funct == FunctJr) || (funct == FunctMthi) || (funct == FunctMtlo) ||
                       ((funct >= FunctMult) && (funct <= FunctDivu)));
    writes_reg = is_load || (opcode == OpJal) ||
                 ((opcode >= OpAddi) && (opcode <= OpLui)) ||
                 ((opcode == OpSpecial) && special_writes);
  end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory stalls and a halt state.
import mips_cpu_pkg::*;

module mips_cpu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       pc_is_zero,
  input  logic       mem_waitrequest,
  output logic [2:0] state,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_enable,
  output logic       pc_enable,
  output logic       reg_write_enable,
  output logic       active
);

  state_e state_q, state_d;
  logic   is_load, is_store, writes_reg;

  mips_cpu_opcode_class u_class (
    .opcode     (opcode),
    .funct      (funct),
    .is_load    (is_load),
    .is_store   (is_store),
    .writes_reg (writes_reg)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (pc_is_zero)            state_d = StHalt;
        else if (!mem_waitrequest) state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_load || is_store) state_d = StMem;
        else if (writes_reg)     state_d = StWb;
        else                     state_d = StFetch;
      end
      StMem: begin
        if (!mem_waitrequest) state_d = is_load ? StWb : StFetch;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Strobes are gated by rst_n so an asserted reset silences them before the state flop clears
  always_comb begin
    state            = state_q;
    active           = (state_q != StHalt);
    mem_read         = rst_n && (((state_q == StFetch) && !pc_is_zero) ||
                                 ((state_q == StMem) && is_load));
    mem_write        = rst_n && (state_q == StMem) && is_store && !is_load;
    ir_enable        = rst_n && (state_q == StFetch) && !pc_is_zero && !mem_waitrequest;
    pc_enable        = rst_n && (state_q == StExec);
    reg_write_enable = rst_n && (state_q == StWb);
  end

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Self-checking bench: cycle-level reference model plus directed literal expectations.
module tb_mips_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       pc_is_zero = 1'b0;
  logic       mem_waitrequest = 1'b0;
  logic [2:0] state;
  logic       mem_read, mem_write, ir_enable, pc_enable, reg_write_enable, active;

  int vectors = 0;
  int miscompares = 0;

  // Literal expectation for the current cycle; mask = {rd, wr, ir, pc, rw, active}
  logic       lit_valid = 1'b0;
  int         lit_state = 0;
  logic [5:0] lit_mask = 6'h00;

  int m_state = 0;

  mips_cpu_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode           (opcode),
    .funct            (funct),
    .pc_is_zero       (pc_is_zero),
    .mem_waitrequest  (mem_waitrequest),
    .state            (state),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .ir_enable        (ir_enable),
    .pc_enable        (pc_enable),
    .reg_write_enable (reg_write_enable),
    .active           (active)
  );

  always #5 clk = ~clk;

  // 0 = other, 1 = writes register, 2 = load, 3 = store
  function automatic int m_kind(input int op, input int fn);
    if (op >= 32 && op <= 38) return 2;
    if (op == 40 || op == 41 || op == 43) return 3;
    if (op == 3 || (op >= 8 && op <= 15)) return 1;
    if (op == 0 && !(fn == 8 || fn == 17 || fn == 19 || (fn >= 24 && fn <= 27))) return 1;
    return 0;
  endfunction

  function automatic int m_next(input int s, input int k, input bit pz, input bit w);
    if (s == 0) return pz ? 5 : (w ? 0 : 1);
    if (s == 1) return 2;
    if (s == 2) return (k >= 2) ? 3 : ((k == 1) ? 4 : 0);
    if (s == 3) return w ? 3 : ((k == 2) ? 4 : 0);
    if (s == 4) return 0;
    return 5;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_state <= 0;
    else        m_state <= m_next(m_state, m_kind(int'(opcode), int'(funct)),
                                  pc_is_zero, mem_waitrequest);
  end

  always begin
    int s, k;
    logic [5:0] em, got;
    @(negedge clk or negedge rst_n);
    #1;
    s = rst_n ? m_state : 0;
    k = m_kind(int'(opcode), int'(funct));
    em = {rst_n && ((s == 0 && !pc_is_zero) || (s == 3 && k == 2)),
          rst_n && s == 3 && k == 3,
          rst_n && s == 0 && !pc_is_zero && !mem_waitrequest,
          rst_n && s == 2,
          rst_n && s == 4,
          s != 5};
    got = {mem_read, mem_write, ir_enable, pc_enable, reg_write_enable, active};
    vectors++;
    if (int'(state) != s || got !== em) begin
      miscompares++;
      $display("FAIL model t=%0t state got %0d want %0d strobes got %b want %b",
               $time, state, s, got, em);
    end
    if (lit_valid) begin
      vectors++;
      if (int'(state) != lit_state || got !== lit_mask) begin
        miscompares++;
        $display("FAIL literal t=%0t op=%h fn=%h state got %0d want %0d strobes got %b want %b",
                 $time, opcode, funct, state, lit_state, got, lit_mask);
      end
      vectors++;
      if (s != lit_state) begin
        miscompares++;
        $display("FAIL model_pin t=%0t model state got %0d want %0d", $time, s, lit_state);
      end
    end
  end

  task automatic cyc(input bit pz, input bit w, input int es, input logic [5:0] em);
    pc_is_zero = pz;
    mem_waitrequest = w;
    lit_state = es;
    lit_mask = em;
    lit_valid = 1'b1;
    @(posedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int kind);
    opcode = op;
    funct = fn;
    cyc(0, 0, 0, 6'b101001);
    cyc(0, 0, 1, 6'b000001);
    cyc(0, 0, 2, 6'b000101);
    if (kind == 1) cyc(0, 0, 4, 6'b000011);
    if (kind == 2) begin
      cyc(0, 0, 3, 6'b100001);
      cyc(0, 0, 4, 6'b000011);
    end
    if (kind == 3) cyc(0, 0, 3, 6'b010001);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
  } vec_t;

  vec_t tbl[$] = '{
    '{6'h03, 6'h00, 1}, '{6'h09, 6'h00, 1}, '{6'h0F, 6'h00, 1}, '{6'h07, 6'h00, 0},
    '{6'h10, 6'h00, 0}, '{6'h00, 6'h18, 0}, '{6'h00, 6'h1B, 0}, '{6'h00, 6'h11, 0},
    '{6'h00, 6'h10, 1}, '{6'h20, 6'h00, 2}, '{6'h26, 6'h00, 2}, '{6'h27, 6'h00, 0},
    '{6'h28, 6'h00, 3}, '{6'h29, 6'h00, 3}, '{6'h2A, 6'h00, 0}, '{6'h24, 6'h00, 2},
    '{6'h2C, 6'h00, 0}, '{6'h00, 6'h13, 0}, '{6'h00, 6'h1C, 1}
  };

  initial begin
    // Reset with fetch-enabling inputs: strobes must stay gated
    lit_state = 0;
    lit_mask = 6'b000001;
    lit_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit_valid = 1'b0;
    rst_n = 1'b1;

    run_instr(6'h00, 6'h21, 1);

    // LW with 3 stalled FETCH cycles and 2 stalled MEM cycles
    opcode = 6'h23;
    funct = 6'h00;
    repeat (3) cyc(0, 1, 0, 6'b100001);
    cyc(0, 0, 0, 6'b101001);
    cyc(0, 0, 1, 6'b000001);
    cyc(0, 0, 2, 6'b000101);
    repeat (2) cyc(0, 1, 3, 6'b100001);
    cyc(0, 0, 3, 6'b100001);
    cyc(0, 0, 4, 6'b000011);

    run_instr(6'h2B, 6'h00, 3);
    run_instr(6'h3F, 6'h00, 0);
    foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].fn, tbl[i].kind);

    // Reset pulled while MEM is stalled on LW
    opcode = 6'h23;
    cyc(0, 0, 0, 6'b101001);
    cyc(0, 0, 1, 6'b000001);
    cyc(0, 0, 2, 6'b000101);
    cyc(0, 1, 3, 6'b100001);
    @(negedge clk);
    #3;
    lit_state = 0;
    lit_mask = 6'b000001;
    lit_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mem_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    lit_valid = 1'b0;
    rst_n = 1'b1;
    run_instr(6'h00, 6'h21, 1);

    // JR then halt address: terminal HALT, no mem_read
    run_instr(6'h00, 6'h08, 0);
    cyc(1, 0, 0, 6'b000001);
    for (int i = 0; i < 10; i++) cyc(i[0], i[1], 5, 6'b000000);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
